// File: rtl/bsg_fsb_to_manycore_tunnel_rx.sv
// rtl/bsg_fsb_to_manycore_tunnel_rx.sv - FSB tunnel receive: tag demux into per-channel FIFOs with batched credit return
module bsg_fsb_to_manycore_tunnel_rx #(
  parameter int ring_width_p   = 80,
  parameter int num_in_p       = 4,
  parameter int width_p        = 16,
  parameter int buffer_els_p   = 8,
  parameter int credit_batch_p = 4,
  parameter int dest_id_p      = 5
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         v_i,
  input  logic [ring_width_p-1:0]      data_i,
  output logic                         ready_o,
  output logic                         v_o,
  output logic [ring_width_p-1:0]      data_o,
  input  logic                         yumi_i,
  output logic [num_in_p-1:0]          chan_v_o,
  output logic [num_in_p*width_p-1:0]  chan_data_o,
  input  logic [num_in_p-1:0]          chan_yumi_i,
  output logic                         error_o
);
  localparam int tag_w    = $clog2(num_in_p + 1);
  localparam int cnt_w    = $clog2(buffer_els_p + 1);
  localparam int tagged_w = tag_w + width_p;
  localparam int ptr_w    = (buffer_els_p > 1) ? $clog2(buffer_els_p) : 1;
  localparam int chan_w   = (num_in_p > 1) ? $clog2(num_in_p) : 1;

  logic [width_p-1:0]      mem_q [num_in_p][buffer_els_p];
  logic [ptr_w-1:0]        rd_ptr_q [num_in_p];
  logic [ptr_w-1:0]        wr_ptr_q [num_in_p];
  logic [cnt_w-1:0]        count_q [num_in_p];
  logic [cnt_w-1:0]        count_d [num_in_p];
  logic [cnt_w-1:0]        cred_q [num_in_p];
  logic [cnt_w-1:0]        cred_d [num_in_p];
  logic                    ready_q, v_q, error_q;
  logic [ring_width_p-1:0] data_q, pkt_d;
  logic [chan_w-1:0]       last_q, grant_d;
  logic                    grant_v_d, load_d, err_set_d;

  logic [tag_w-1:0]        tag;
  logic                    accept;
  logic [num_in_p-1:0]     push, pop, full, elig;
  logic                    unused_hdr;

  // Header bits above the tagged word carry nothing this block needs.
  assign unused_hdr = ^data_i[ring_width_p-1:tagged_w];

  assign tag    = data_i[tagged_w-1 -: tag_w];
  assign accept = v_i & ready_q;

  assign ready_o = ready_q;
  assign v_o     = v_q;
  assign data_o  = data_q;
  assign error_o = error_q;

  // Per-channel push/pop decode, FIFO occupancy, credit bookkeeping and round-robin credit arbitration.
  always_comb begin
    logic [cnt_w:0] sum;
    logic [cnt_w-1:0] loaded;
    int idx;
    err_set_d = 1'b0;
    grant_v_d = 1'b0;
    grant_d   = '0;
    idx       = 0;
    sum       = '0;
    loaded    = '0;
    if (accept && (tag >= tag_w'(num_in_p))) err_set_d = 1'b1;
    for (int t = 0; t < num_in_p; t++) begin
      chan_v_o[t] = (count_q[t] != '0);
      chan_data_o[t*width_p +: width_p] = mem_q[t][rd_ptr_q[t]];
      full[t] = (count_q[t] == cnt_w'(buffer_els_p));
      pop[t]  = chan_yumi_i[t] & (count_q[t] != '0);
      push[t] = accept && (tag == tag_w'(t)) && (!full[t] || pop[t]);
      if (accept && (tag == tag_w'(t)) && full[t] && !pop[t]) err_set_d = 1'b1;
      count_d[t] = count_q[t] + cnt_w'(push[t]) - cnt_w'(pop[t]);
      // A channel returns credits once a batch has built up, or as soon as its FIFO has drained.
      elig[t] = (cred_q[t] >= cnt_w'(credit_batch_p)) ||
                ((cred_q[t] != '0) && (count_q[t] == '0));
    end
    for (int i = 1; i <= num_in_p; i++) begin
      idx = (int'(last_q) + i) % num_in_p;
      if (!grant_v_d && elig[idx]) begin
        grant_v_d = 1'b1;
        grant_d   = chan_w'(idx);
      end
    end
    load_d = grant_v_d && (!v_q || yumi_i);
    pkt_d = '0;
    pkt_d[ring_width_p-1 -: 4]  = 4'(dest_id_p);
    pkt_d[tagged_w-1 -: tag_w]  = tag_w'(num_in_p);
    pkt_d[cnt_w-1:0]            = cred_q[grant_d];
    pkt_d[cnt_w +: tag_w]       = tag_w'(grant_d);
    for (int t = 0; t < num_in_p; t++) begin
      loaded = (load_d && (grant_d == chan_w'(t))) ? cred_q[t] : '0;
      sum = {1'b0, cred_q[t]} - {1'b0, loaded} + (cnt_w+1)'(chan_yumi_i[t]);
      if (sum > (cnt_w+1)'(buffer_els_p)) begin
        cred_d[t] = cnt_w'(buffer_els_p);
        err_set_d = 1'b1;
      end else begin
        cred_d[t] = sum[cnt_w-1:0];
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    for (int t = 0; t < num_in_p; t++) begin
      if (push[t]) mem_q[t][wr_ptr_q[t]] <= data_i[width_p-1:0];
    end
  end

  // Control state: ready, credit output register, sticky error, pointers and counters.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      ready_q <= 1'b0;
      v_q     <= 1'b0;
      data_q  <= '0;
      error_q <= 1'b0;
      last_q  <= chan_w'(num_in_p - 1);
      for (int t = 0; t < num_in_p; t++) begin
        rd_ptr_q[t] <= '0;
        wr_ptr_q[t] <= '0;
        count_q[t]  <= '0;
        cred_q[t]   <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      if (load_d) begin
        v_q    <= 1'b1;
        data_q <= pkt_d;
        last_q <= grant_d;
      end else if (yumi_i) begin
        v_q <= 1'b0;
      end
      if (err_set_d) error_q <= 1'b1;
      for (int t = 0; t < num_in_p; t++) begin
        if (push[t]) wr_ptr_q[t] <= (wr_ptr_q[t] == ptr_w'(buffer_els_p - 1)) ? '0 : wr_ptr_q[t] + 1'b1;
        if (pop[t])  rd_ptr_q[t] <= (rd_ptr_q[t] == ptr_w'(buffer_els_p - 1)) ? '0 : rd_ptr_q[t] + 1'b1;
        count_q[t] <= count_d[t];
        cred_q[t]  <= cred_d[t];
      end
    end
  end
endmodule

// File: tb/tb_bsg_fsb_to_manycore_tunnel_rx.sv
// tb/tb_bsg_fsb_to_manycore_tunnel_rx.sv - directed table-driven bench for the FSB tunnel receiver
module tb_bsg_fsb_to_manycore_tunnel_rx;
  localparam int NI = 4, W = 16, BE = 8, CB = 4, DID = 5, RW = 80;

  logic            clk = 1'b0;
  logic            reset_n, v_i, ready_o, v_o, yumi_i, error_o;
  logic [RW-1:0]   data_i, data_o;
  logic [NI-1:0]   chan_v_o, chan_yumi_i;
  logic [NI*W-1:0] chan_data_o;
  int              n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  bsg_fsb_to_manycore_tunnel_rx #(
    .ring_width_p(RW), .num_in_p(NI), .width_p(W),
    .buffer_els_p(BE), .credit_batch_p(CB), .dest_id_p(DID)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .chan_v_o(chan_v_o),
    .chan_data_o(chan_data_o), .chan_yumi_i(chan_yumi_i), .error_o(error_o)
  );

  typedef struct {
    logic v; logic [2:0] tag; logic [15:0] pay; logic [3:0] cy; logic y;
    logic [3:0] chv; logic [3:0][15:0] head; logic vo; logic [RW-1:0] dout; logic err;
  } vec_t;

  vec_t tbl[16];

  function automatic logic [RW-1:0] mk(input logic [2:0] tag, input logic [15:0] pay);
    logic [60:0] hdr;
    hdr = 61'h0ABC_DEF0_1234_5678;
    return {hdr, tag, pay};
  endfunction

  function automatic logic [RW-1:0] cp(input int t, input int cnt);
    return {4'(DID), 1'b0, 56'd0, 3'(NI), 9'd0, 3'(t), 4'(cnt)};
  endfunction

  function automatic vec_t setv(input logic v, input logic [2:0] tag, input logic [15:0] pay,
                                input logic [3:0] cy, input logic y, input logic [3:0] chv,
                                input logic [63:0] head, input logic vo, input logic [RW-1:0] dout);
    vec_t r;
    r.v = v; r.tag = tag; r.pay = pay; r.cy = cy; r.y = y;
    r.chv = chv; r.head = head; r.vo = vo; r.dout = dout; r.err = 1'b0;
    return r;
  endfunction

  function automatic logic [15:0] head(input int t);
    return chan_data_o[t*W +: W];
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [2:0] tag, input logic [15:0] pay,
                     input logic [3:0] cy, input logic y);
    v_i = v; data_i = v ? mk(tag, pay) : '0; chan_yumi_i = cy; yumi_i = y;
    @(posedge clk); @(negedge clk);
    v_i = 1'b0; data_i = '0; chan_yumi_i = '0; yumi_i = 1'b0;
  endtask

  task automatic do_reset(input logic check);
    reset_n = 1'b0; v_i = 1'b0; data_i = '0; chan_yumi_i = '0; yumi_i = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (check) begin
        chk("rst_ready", RW'(ready_o), RW'(0));
        chk("rst_v_o", RW'(v_o), RW'(0));
        chk("rst_data_o", data_o, '0);
        chk("rst_chan_v", RW'(chan_v_o), RW'(0));
        chk("rst_error", RW'(error_o), RW'(0));
      end
    end
    reset_n = 1'b1;
    if (check) chk("ready_before_edge", RW'(ready_o), RW'(0));
    @(posedge clk); @(negedge clk);
    chk("ready_after_release", RW'(ready_o), RW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Routing, flush returns and per-cycle hold behaviour.
    tbl[0]  = setv(1, 3'd2, 16'hA0A0, 4'b0000, 0, 4'b0100, {16'h0, 16'hA0A0, 16'h0, 16'h0}, 0, '0);
    tbl[1]  = setv(1, 3'd0, 16'hB1B1, 4'b0000, 0, 4'b0101, {16'h0, 16'hA0A0, 16'h0, 16'hB1B1}, 0, '0);
    tbl[2]  = setv(1, 3'd2, 16'hC2C2, 4'b0000, 0, 4'b0101, {16'h0, 16'hA0A0, 16'h0, 16'hB1B1}, 0, '0);
    tbl[3]  = setv(0, 3'd0, 16'h0000, 4'b0100, 0, 4'b0101, {16'h0, 16'hC2C2, 16'h0, 16'hB1B1}, 0, '0);
    tbl[4]  = setv(0, 3'd0, 16'h0000, 4'b0000, 0, 4'b0101, {16'h0, 16'hC2C2, 16'h0, 16'hB1B1}, 0, '0);
    tbl[5]  = setv(0, 3'd0, 16'h0000, 4'b0001, 0, 4'b0100, {16'h0, 16'hC2C2, 16'h0, 16'h0}, 0, '0);
    tbl[6]  = setv(0, 3'd0, 16'h0000, 4'b0000, 0, 4'b0100, {16'h0, 16'hC2C2, 16'h0, 16'h0}, 1, cp(0, 1));
    tbl[7]  = setv(0, 3'd0, 16'h0000, 4'b0000, 1, 4'b0100, {16'h0, 16'hC2C2, 16'h0, 16'h0}, 0, '0);
    tbl[8]  = setv(0, 3'd0, 16'h0000, 4'b0100, 0, 4'b0000, 64'h0, 0, '0);
    tbl[9]  = setv(0, 3'd0, 16'h0000, 4'b0000, 0, 4'b0000, 64'h0, 1, cp(2, 2));
    tbl[10] = setv(0, 3'd0, 16'h0000, 4'b0000, 0, 4'b0000, 64'h0, 1, cp(2, 2));
    tbl[11] = setv(0, 3'd0, 16'h0000, 4'b0000, 1, 4'b0000, 64'h0, 0, '0);
    tbl[12] = setv(1, 3'd3, 16'h3333, 4'b0000, 0, 4'b1000, {16'h3333, 16'h0, 16'h0, 16'h0}, 0, '0);
    tbl[13] = setv(0, 3'd0, 16'h0000, 4'b1000, 0, 4'b0000, 64'h0, 0, '0);
    tbl[14] = setv(0, 3'd0, 16'h0000, 4'b0000, 0, 4'b0000, 64'h0, 1, cp(3, 1));
    tbl[15] = setv(0, 3'd0, 16'h0000, 4'b0000, 1, 4'b0000, 64'h0, 0, '0);

    do_reset(1'b1);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].v, tbl[i].tag, tbl[i].pay, tbl[i].cy, tbl[i].y);
      chk($sformatf("tbl%0d_chan_v", i), RW'(chan_v_o), RW'(tbl[i].chv));
      chk($sformatf("tbl%0d_v_o", i), RW'(v_o), RW'(tbl[i].vo));
      chk($sformatf("tbl%0d_error", i), RW'(error_o), RW'(tbl[i].err));
      if (tbl[i].vo) chk($sformatf("tbl%0d_data_o", i), data_o, tbl[i].dout);
      for (int t = 0; t < NI; t++)
        if (tbl[i].chv[t]) chk($sformatf("tbl%0d_head%0d", i, t), RW'(head(t)), RW'(tbl[i].head[t]));
    end

    // Batch return on chan 1, full-FIFO push+pop, hold stability, then reset with a pending packet.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) cyc(1, 3'd1, 16'h1000 + 16'(i), 4'b0000, 0);
    chk("batch_chan_v", RW'(chan_v_o), RW'(4'b0010));
    chk("batch_head_first", RW'(head(1)), RW'(16'h1000));
    cyc(1, 3'd1, 16'h1008, 4'b0010, 0);
    chk("full_pushpop_error", RW'(error_o), RW'(0));
    chk("full_pushpop_head", RW'(head(1)), RW'(16'h1001));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 3'd0, 16'h0, 4'b0010, 0);
      chk($sformatf("batch_pop%0d_head", i), RW'(head(1)), RW'(16'h1002 + 16'(i)));
      chk($sformatf("batch_pop%0d_v_o", i), RW'(v_o), RW'(0));
    end
    cyc(0, 3'd0, 16'h0, 4'b0000, 0);
    chk("batch_v_o", RW'(v_o), RW'(1));
    chk("batch_data_o", data_o, cp(1, 4));
    for (int i = 0; i < 5; i++) begin
      cyc(0, 3'd0, 16'h0, 4'b0000, 0);
      chk($sformatf("hold%0d_v_o", i), RW'(v_o), RW'(1));
      chk($sformatf("hold%0d_data_o", i), data_o, cp(1, 4));
    end
    reset_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("midrst_v_o", RW'(v_o), RW'(0));
    chk("midrst_data_o", data_o, '0);
    chk("midrst_chan_v", RW'(chan_v_o), RW'(0));
    chk("midrst_ready", RW'(ready_o), RW'(0));

    // Simultaneous chan yumi on load, and round-robin between two eligible channels.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) cyc(1, 3'd0, 16'h0A00 + 16'(i), 4'b0000, 0);
    for (int i = 0; i < 4; i++) cyc(1, 3'd2, 16'h0C00 + 16'(i), 4'b0000, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 3'd0, 16'h0, 4'b0101, 0);
      chk($sformatf("sim_pop%0d_v_o", i), RW'(v_o), RW'(0));
    end
    chk("sim_head0", RW'(head(0)), RW'(16'h0A04));
    cyc(0, 3'd0, 16'h0, 4'b0001, 0);
    chk("sim_load0_v_o", RW'(v_o), RW'(1));
    chk("sim_load0_data", data_o, cp(0, 4));
    cyc(0, 3'd0, 16'h0, 4'b0000, 1);
    chk("rr_grant2_v_o", RW'(v_o), RW'(1));
    chk("rr_grant2_data", data_o, cp(2, 4));
    cyc(0, 3'd0, 16'h0, 4'b0000, 1);
    chk("rr_grant0_v_o", RW'(v_o), RW'(1));
    chk("rr_grant0_data", data_o, cp(0, 1));
    cyc(0, 3'd0, 16'h0, 4'b0000, 1);
    chk("rr_drained_v_o", RW'(v_o), RW'(0));

    // Overflow: ninth push to a full channel is dropped and sets the sticky error.
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) cyc(1, 3'd1, 16'h2000 + 16'(i), 4'b0000, 0);
    chk("ovf_pre_error", RW'(error_o), RW'(0));
    cyc(1, 3'd1, 16'h2FFF, 4'b0000, 0);
    chk("ovf_error", RW'(error_o), RW'(1));
    chk("ovf_head", RW'(head(1)), RW'(16'h2000));
    for (int i = 0; i < 8; i++) begin
      cyc(0, 3'd0, 16'h0, 4'b0010, 0);
      if (i < 7) chk($sformatf("ovf_pop%0d_head", i), RW'(head(1)), RW'(16'h2001 + 16'(i)));
    end
    chk("ovf_drained_chan_v", RW'(chan_v_o), RW'(0));
    chk("ovf_error_sticky", RW'(error_o), RW'(1));
    do_reset(1'b0);
    chk("ovf_error_cleared", RW'(error_o), RW'(0));

    // Illegal tag equal to num_in_p is dropped and flagged.
    cyc(1, 3'(NI), 16'h4444, 4'b0000, 0);
    chk("badtag_error", RW'(error_o), RW'(1));
    chk("badtag_chan_v", RW'(chan_v_o), RW'(0));
    cyc(0, 3'd0, 16'h0, 4'b0000, 0);
    chk("badtag_error_sticky", RW'(error_o), RW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
